// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_seq_pkg;
  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between a multiply requester and mult_seq.
interface mult_seq_if #(
  parameter int unsigned WIDTH = mult_seq_pkg::WIDTH_DEFAULT
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);
endinterface

// File: rtl/mult_seq_pp_gate.sv
// Partial-product gate: a vector ANDed with one bit replicated across it.
module pp_gate #(
  parameter int unsigned WIDTH = mult_seq_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             sel,
  output logic [WIDTH-1:0] pp
);
  assign pp = vec & {WIDTH{sel}};
endmodule

// File: rtl/mult_seq.sv
// Unsigned WIDTH x WIDTH multiplier, one shift-add iteration per clock.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  mult_seq_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state, state_nx;
  logic [WIDTH-1:0]     mcand, mcand_nx;
  logic [WIDTH-1:0]     hi, hi_nx;
  logic [WIDTH-1:0]     lo, lo_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [2*WIDTH-1:0]   product_q, product_nx;
  logic [WIDTH-1:0]     pp;
  logic [WIDTH:0]       sum;
  logic                 ready_q, busy_q, done_q;

  pp_gate #(.WIDTH(WIDTH)) u_pp_gate (
    .vec (mcand),
    .sel (lo[0]),
    .pp  (pp)
  );

  assign sum = {1'b0, hi} + {1'b0, pp};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      mcand     <= mcand_nx;
      hi        <= hi_nx;
      lo        <= lo_nx;
      cnt       <= cnt_nx;
      product_q <= product_nx;
      ready_q   <= (state_nx != RUN);
      busy_q    <= (state_nx == RUN);
      done_q    <= (state_nx == DONE);
    end
  end

  // Next state and datapath; start is only honoured outside RUN
  always_comb begin
    state_nx   = state;
    mcand_nx   = mcand;
    hi_nx      = hi;
    lo_nx      = lo;
    cnt_nx     = cnt;
    product_nx = product_q;
    case (state)
      RUN: begin
        hi_nx  = sum[WIDTH:1];
        lo_nx  = {sum[0], lo[WIDTH-1:1]};
        cnt_nx = cnt + CW'(1);
        if (cnt == LAST) begin
          state_nx   = DONE;
          product_nx = {sum, lo[WIDTH-1:1]};
        end
      end
      IDLE, DONE: begin
        state_nx = IDLE;
        if (bus.start) begin
          state_nx = RUN;
          mcand_nx = bus.a;
          lo_nx    = bus.b;
          hi_nx    = '0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomised checks of mult_seq against a transaction-level model.
module tb_mult_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   cmp_on = 1'b0;

  mult_seq_if #(.WIDTH(W)) ifc ();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: an accepted request yields done and a*b exactly W edges later
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [63:0] m_pend;
  logic [63:0] m_prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_prod <= '0;
      m_pend <= '0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (ifc.start) begin
        m_busy <= 1'b1;
        m_left <= W;
        m_pend <= 64'(ifc.a) * 64'(ifc.b);
      end
    end
  end

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!reset && cmp_on) begin
      check("busy", 64'(ifc.busy), 64'(m_busy));
      check("ready", 64'(ifc.ready), 64'(!m_busy));
      check("done", 64'(ifc.done), 64'(m_done));
      check("product", ifc.product, m_prod);
      check("busy_ready_excl", 64'(ifc.busy & ifc.ready), 64'd0);
      check("done_width", 64'(prev_done & ifc.done), 64'd0);
    end
    prev_done = ifc.done;
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!ifc.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ifc.done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] lit, input string name);
    int n;
    ifc.start = 1'b1;
    ifc.a = a;
    ifc.b = b;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.a = $urandom;
    ifc.b = $urandom;
    wait_done(name, n);
    check({name, "_latency"}, 64'(n), 64'(W));
    check({name, "_product"}, ifc.product, lit);
  endtask

  initial begin
    int n;
    bit seen;
    bit chk_next;
    logic [W-1:0] ra, rb;

    ifc.start = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    #23;
    check("rst_ready", 64'(ifc.ready), 64'd1);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst_done", 64'(ifc.done), 64'd0);
    check("rst_product", ifc.product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cmp_on = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-run aborts without a done pulse
    ifc.start = 1'b1;
    ifc.a = 32'd100;
    ifc.b = 32'd200;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_ready", 64'(ifc.ready), 64'd1);
    check("abort_busy", 64'(ifc.busy), 64'd0);
    check("abort_done", 64'(ifc.done), 64'd0);
    check("abort_product", ifc.product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_after", 64'(ifc.ready), 64'd1);
    do_mult(32'd100, 32'd200, 64'd20000, "after_abort");

    do_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F, "three_five");
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_max");
    do_mult(32'd0, 32'h1234_5678, 64'd0, "zero_a");
    do_mult(32'h1234_5678, 32'd0, 64'd0, "zero_b");
    do_mult(32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, "one_max");
    do_mult(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msb_shift");

    // Start during RUN is ignored
    ifc.start = 1'b1;
    ifc.a = 32'd9;
    ifc.b = 32'd11;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.a = 32'd1000;
    ifc.b = 32'd1000;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    wait_done("ignored_start", n);
    check("ignored_start_product", ifc.product, 64'd99);
    check("ignored_start_latency", 64'(n + 6), 64'(W));

    // Start held high: back-to-back runs with no IDLE gap
    ifc.start = 1'b1;
    ifc.a = 32'd7;
    ifc.b = 32'd6;
    seen = 1'b0;
    chk_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      ifc.a = $urandom;
      ifc.b = $urandom;
      if (chk_next) begin
        check("b2b_busy_after_done", 64'(ifc.busy), 64'd1);
        chk_next = 1'b0;
      end
      if (ifc.done && !seen) begin
        check("b2b_first_product", ifc.product, 64'd42);
        seen = 1'b1;
        chk_next = 1'b1;
      end
    end
    ifc.start = 1'b0;
    check("b2b_first_seen", 64'(seen), 64'd1);
    wait_done("b2b_second", n);
    @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_mult(ra, rb, 64'(ra) * 64'(rb), "random");
    end

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
